add_sub_seq: RTL and testbench
==============================

ADD_SUB_SEQ -- requirements
Module: add_sub_seq

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, operand/result width in bits (>=2).
REQ-002 The module SHALL have parameter DIGIT, default 1, bits processed per cycle (1..WIDTH, WIDTH % DIGIT == 0).
REQ-003 The module SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 The module SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The module SHALL have port in_valid  input  1  operands and mode present.
REQ-006 The module SHALL have port in_ready  output  1  block can accept an operation.
REQ-007 The module SHALL have ports a and b  input  WIDTH  operands.
REQ-008 The module SHALL have port sub_mode  input  1  0 = a+b, 1 = a-b.
REQ-009 The module SHALL have port out_valid  output  1  result registers valid.
REQ-010 The module SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 The module SHALL have port res  output  WIDTH  result.
REQ-012 The module SHALL have port carry  output  1  unsigned carry-out (subtract: 1 = no borrow).
REQ-013 The module SHALL have port overflow  output  1  two's-complement signed overflow.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-015 In IDLE, in_valid=1 SHALL capture a, b and sub_mode, clear the digit counter, load carry-in = sub_mode, and enter RUN.
REQ-016 In RUN, each cycle SHALL add one DIGIT-bit slice, LSB slice first: a_slice + (b_slice XOR {DIGIT{sub_mode}}) + carry_reg.
REQ-017 The slice sum SHALL be stored into res at that slice's position, and carry_reg SHALL be updated with the slice carry-out.
REQ-018 RUN SHALL last exactly WIDTH/DIGIT cycles; after the last slice the FSM SHALL enter DONE, with out_valid asserted WIDTH/DIGIT cycles after the accepting edge.
REQ-019 On entry to DONE, carry SHALL equal the final carry_reg, and overflow SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-020 DONE SHALL hold res, carry and overflow stable until out_valid && out_ready, then return to IDLE; a new operation is accepted no earlier than the following cycle.
REQ-021 Operand inputs SHALL be ignored outside the IDLE accept cycle, and changes during RUN or DONE SHALL not affect the result.
REQ-022 When DIGIT == WIDTH, RUN SHALL take exactly 1 cycle.

Reset
REQ-023 rst=1 at a rising edge SHALL force state IDLE, res=0, carry=0, overflow=0, out_valid=0, in_ready=1 and the counter to 0, overriding all other inputs.
REQ-024 Asserting rst mid-RUN or mid-DONE SHALL abort the operation; the partial result SHALL be discarded and never presented.

Configuration
REQ-025 The macro ADD_SUB_SEQ_SAT_EN SHALL control signed saturation.
REQ-026 With ADD_SUB_SEQ_SAT_EN defined, when overflow=1 on entry to DONE, res SHALL be replaced by 0x7F..F if the a operand MSB is 0, or 0x80..0 if it is 1; overflow SHALL still read 1 and carry SHALL be unaffected.
REQ-027 Without ADD_SUB_SEQ_SAT_EN, res SHALL be the wrapped modulo-2^WIDTH result, and no saturation logic SHALL be present.

Verification
REQ-028 The bench SHALL check that WIDTH=8, DIGIT=1: a=0x00, b=0x01, sub_mode=0 -> out_valid 8 cycles after accept, res=0x01, carry=0, overflow=0.
REQ-029 The bench SHALL check that WIDTH=8, DIGIT=1: a=0x00, b=0x01, sub_mode=1 -> res=0xFF, carry=0 (borrow), overflow=0.
REQ-030 The bench SHALL check that WIDTH=8: a=0x7F, b=0x01, add -> overflow=1; res=0x80 without the macro and res=0x7F with ADD_SUB_SEQ_SAT_EN.
REQ-031 The bench SHALL check that WIDTH=8, DIGIT=4: a=0xFF, b=0x01, add -> res=0x00, carry=1, overflow=0, out_valid 2 cycles after accept.
REQ-032 The bench SHALL check that with out_ready held 0 for 5 cycles in DONE, res, carry and out_valid stay stable and in_ready=0; out_ready=1 then gives IDLE on the next edge.
REQ-033 The bench SHALL check that rst pulsed on the 3rd RUN cycle gives out_valid=0, res=0, in_ready=1 on the next cycle, and that a following 0x05+0x03 gives res=0x08.

Source files
------------

// File: rtl/add_sub_seq_if.sv
// Operand/result bundle for the digit-serial adder/subtractor.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
interface add_sub_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic             overflow;

    // Producer/consumer side: drives operands and result acceptance.
    modport master (
        output in_valid, a, b, sub_mode, out_ready,
        input  in_ready, out_valid, res, carry, overflow
    );

    // Arithmetic block side.
    modport slave (
        input  in_valid, a, b, sub_mode, out_ready,
        output in_ready, out_valid, res, carry, overflow
    );
endinterface

// File: rtl/add_sub_seq.sv
// Digit-serial add/subtract: DIGIT bits per cycle, LSB slice first; optional signed saturation (ADD_SUB_SEQ_SAT_EN).
// Latency: WIDTH/DIGIT cycles from the accepting edge to out_valid.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_valid && out_ready.
module add_sub_seq #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic           clk,
    input  logic           rst,
    add_sub_seq_if.slave   bus
);

    localparam int NSL   = WIDTH / DIGIT;
    localparam int CNT_W = (NSL > 1) ? $clog2(NSL) : 1;

    // Reject parameter combinations the slicing cannot represent.
    generate
        if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
            $error("add_sub_seq: illegal WIDTH/DIGIT combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;

    // Captured operation; operands are frozen here so the bus may change freely after accept.
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               mode_q;

    // Running carry between slices and the slice index being processed.
    logic               cy_q;
    logic [CNT_W-1:0]   cnt_q;

    // Result registers presented on the bus.
    logic [WIDTH-1:0]   res_q;
    logic [WIDTH-1:0]   res_d;
    logic               carry_q;
    logic               ovf_q;

    // Current-slice datapath.
    logic [DIGIT-1:0]   a_sl;
    logic [DIGIT-1:0]   b_sl;
    logic [DIGIT-1:0]   b_x;
    logic [DIGIT-1:0]   sum_sl;
    logic [DIGIT:0]     c_chain;
    logic               ovf_d;

    logic               last_sl;
    logic               accept;
    logic               in_ready_c;
    logic               out_valid_c;

    assign last_sl = (cnt_q == CNT_W'(NSL - 1));
    assign accept  = (state_q == IDLE) && bus.in_valid;

    // State register; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs decoded from the current state.
    always_comb begin
        state_d     = state_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last_sl) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.res       = res_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = ovf_q;

    // Select the operand slices addressed by the digit counter.
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int s = 0; s < NSL; s++) begin
            if (cnt_q == CNT_W'(s)) begin
                a_sl = a_q[s*DIGIT +: DIGIT];
                b_sl = b_q[s*DIGIT +: DIGIT];
            end
        end
    end

    // Subtraction is a + ~b + 1: invert b here, the +1 comes from the initial carry-in.
    assign b_x = b_sl ^ {DIGIT{mode_q}};

    // Bit-level ripple inside the slice so the carry into the MSB is available for overflow.
    always_comb begin
        c_chain    = '0;
        sum_sl     = '0;
        c_chain[0] = cy_q;
        for (int i = 0; i < DIGIT; i++) begin
            sum_sl[i]    = a_sl[i] ^ b_x[i] ^ c_chain[i];
            c_chain[i+1] = (a_sl[i] & b_x[i]) | (a_sl[i] & c_chain[i]) | (b_x[i] & c_chain[i]);
        end
    end

    // Only meaningful on the last slice, where bit DIGIT-1 is the operand MSB.
    assign ovf_d = c_chain[DIGIT] ^ c_chain[DIGIT-1];

    // Merge the slice sum into the result; clamp on signed overflow when saturation is built in.
    always_comb begin
        res_d = res_q;
        for (int s = 0; s < NSL; s++) begin
            if (cnt_q == CNT_W'(s)) begin
                res_d[s*DIGIT +: DIGIT] = sum_sl;
            end
        end
`ifdef ADD_SUB_SEQ_SAT_EN
        if (last_sl && ovf_d) begin
            // Both operands (after inversion) share a's sign when overflow occurs, so a's MSB picks the rail.
            res_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    // Operand capture on accept, one slice per RUN cycle, flags latched on the last slice.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= 1'b0;
            cy_q    <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            mode_q  <= bus.sub_mode;
            cy_q    <= bus.sub_mode;
            cnt_q   <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (state_q == RUN) begin
            res_q <= res_d;
            cy_q  <= c_chain[DIGIT];
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_sl) begin
                carry_q <= c_chain[DIGIT];
                ovf_q   <= ovf_d;
            end
        end
    end

endmodule

// File: tb/tb_add_sub_seq.sv
// Directed bench for add_sub_seq: a bit-serial (DIGIT=1) and a nibble-serial (DIGIT=4) instance.
// Latency: checks out_valid appears WIDTH/DIGIT cycles after accept.
// Backpressure: checks DONE holds under out_ready=0 and returns to IDLE on release.
module tb_add_sub_seq;

    logic clk;
    logic rst;

    int n_checks;
    int n_fail;

    add_sub_seq_if #(.WIDTH(8)) i1 ();
    add_sub_seq_if #(.WIDTH(8)) i4 ();

    add_sub_seq #(.WIDTH(8), .DIGIT(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (i1)
    );

    add_sub_seq #(.WIDTH(8), .DIGIT(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (i4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operation to the DIGIT=1 instance and count edges until out_valid.
    // Operands are scrambled after accept; the result must not depend on them.
    task automatic run_op1(input logic [7:0] av, input logic [7:0] bv, input logic sm, output int n);
        @(negedge clk);
        i1.a        = av;
        i1.b        = bv;
        i1.sub_mode = sm;
        i1.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i1.in_valid = 1'b0;
        i1.a        = ~av;
        i1.b        = 8'hA5;
        i1.sub_mode = ~sm;
        n = 0;
        while (!i1.out_valid && n < 50) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
    endtask

    task automatic release1();
        i1.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i1.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (i1.in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", i1.in_ready); end
        n_checks++; if (i1.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", i1.out_valid); end
        n_checks++; if (i1.res !== 8'h00)      begin n_fail++; $display("FAIL reset_res got=%h exp=00", i1.res); end
        n_checks++; if (i1.carry !== 1'b0)     begin n_fail++; $display("FAIL reset_carry got=%b exp=0", i1.carry); end
        n_checks++; if (i1.overflow !== 1'b0)  begin n_fail++; $display("FAIL reset_overflow got=%b exp=0", i1.overflow); end
        n_checks++; if (i4.in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready4 got=%b exp=1", i4.in_ready); end
    endtask

    task automatic test_add();
        int n;
        run_op1(8'h00, 8'h01, 1'b0, n);
        n_checks++; if (n !== 8)               begin n_fail++; $display("FAIL add_latency got=%0d exp=8", n); end
        n_checks++; if (i1.res !== 8'h01)      begin n_fail++; $display("FAIL add_res got=%h exp=01", i1.res); end
        n_checks++; if (i1.carry !== 1'b0)     begin n_fail++; $display("FAIL add_carry got=%b exp=0", i1.carry); end
        n_checks++; if (i1.overflow !== 1'b0)  begin n_fail++; $display("FAIL add_overflow got=%b exp=0", i1.overflow); end
        n_checks++; if (i1.in_ready !== 1'b0)  begin n_fail++; $display("FAIL add_in_ready_done got=%b exp=0", i1.in_ready); end
        release1();
        n_checks++; if (i1.in_ready !== 1'b1)  begin n_fail++; $display("FAIL add_back_idle got=%b exp=1", i1.in_ready); end
    endtask

    task automatic test_sub();
        int n;
        // 0 - 1: borrow, no signed overflow.
        run_op1(8'h00, 8'h01, 1'b1, n);
        n_checks++; if (n !== 8)               begin n_fail++; $display("FAIL sub_latency got=%0d exp=8", n); end
        n_checks++; if (i1.res !== 8'hFF)      begin n_fail++; $display("FAIL sub_res got=%h exp=ff", i1.res); end
        n_checks++; if (i1.carry !== 1'b0)     begin n_fail++; $display("FAIL sub_carry got=%b exp=0", i1.carry); end
        n_checks++; if (i1.overflow !== 1'b0)  begin n_fail++; $display("FAIL sub_overflow got=%b exp=0", i1.overflow); end
        release1();
        // 5 - 3: no borrow, carry reads 1.
        run_op1(8'h05, 8'h03, 1'b1, n);
        n_checks++; if (i1.res !== 8'h02)      begin n_fail++; $display("FAIL sub2_res got=%h exp=02", i1.res); end
        n_checks++; if (i1.carry !== 1'b1)     begin n_fail++; $display("FAIL sub2_carry got=%b exp=1", i1.carry); end
        release1();
    endtask

    task automatic test_overflow();
        int n;
        logic [7:0] exp_pos;
        logic [7:0] exp_neg;
`ifdef ADD_SUB_SEQ_SAT_EN
        exp_pos = 8'h7F;
        exp_neg = 8'h80;
`else
        exp_pos = 8'h80;
        exp_neg = 8'h7F;
`endif
        // 127 + 1 overflows positive.
        run_op1(8'h7F, 8'h01, 1'b0, n);
        n_checks++; if (i1.overflow !== 1'b1)  begin n_fail++; $display("FAIL ovf_pos_flag got=%b exp=1", i1.overflow); end
        n_checks++; if (i1.res !== exp_pos)    begin n_fail++; $display("FAIL ovf_pos_res got=%h exp=%h", i1.res, exp_pos); end
        n_checks++; if (i1.carry !== 1'b0)     begin n_fail++; $display("FAIL ovf_pos_carry got=%b exp=0", i1.carry); end
        release1();
        // -128 - 1 overflows negative; unsigned view has no borrow.
        run_op1(8'h80, 8'h01, 1'b1, n);
        n_checks++; if (i1.overflow !== 1'b1)  begin n_fail++; $display("FAIL ovf_neg_flag got=%b exp=1", i1.overflow); end
        n_checks++; if (i1.res !== exp_neg)    begin n_fail++; $display("FAIL ovf_neg_res got=%h exp=%h", i1.res, exp_neg); end
        n_checks++; if (i1.carry !== 1'b1)     begin n_fail++; $display("FAIL ovf_neg_carry got=%b exp=1", i1.carry); end
        release1();
    endtask

    task automatic test_digit4();
        int n;
        @(negedge clk);
        i4.a        = 8'hFF;
        i4.b        = 8'h01;
        i4.sub_mode = 1'b0;
        i4.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i4.in_valid = 1'b0;
        i4.a        = 8'h3C;
        i4.b        = 8'h77;
        n = 0;
        while (!i4.out_valid && n < 50) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        n_checks++; if (n !== 2)               begin n_fail++; $display("FAIL d4_latency got=%0d exp=2", n); end
        n_checks++; if (i4.res !== 8'h00)      begin n_fail++; $display("FAIL d4_res got=%h exp=00", i4.res); end
        n_checks++; if (i4.carry !== 1'b1)     begin n_fail++; $display("FAIL d4_carry got=%b exp=1", i4.carry); end
        n_checks++; if (i4.overflow !== 1'b0)  begin n_fail++; $display("FAIL d4_overflow got=%b exp=0", i4.overflow); end
        i4.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i4.out_ready = 1'b0;
        n_checks++; if (i4.in_ready !== 1'b1)  begin n_fail++; $display("FAIL d4_back_idle got=%b exp=1", i4.in_ready); end
    endtask

    task automatic test_hold();
        int n;
        run_op1(8'h12, 8'h34, 1'b0, n);
        for (int c = 0; c < 5; c++) begin
            n_checks++; if (i1.out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_out_valid cyc=%0d got=%b exp=1", c, i1.out_valid); end
            n_checks++; if (i1.res !== 8'h46)      begin n_fail++; $display("FAIL hold_res cyc=%0d got=%h exp=46", c, i1.res); end
            n_checks++; if (i1.carry !== 1'b0)     begin n_fail++; $display("FAIL hold_carry cyc=%0d got=%b exp=0", c, i1.carry); end
            n_checks++; if (i1.in_ready !== 1'b0)  begin n_fail++; $display("FAIL hold_in_ready cyc=%0d got=%b exp=0", c, i1.in_ready); end
            @(posedge clk);
            @(negedge clk);
        end
        release1();
        n_checks++; if (i1.in_ready !== 1'b1)  begin n_fail++; $display("FAIL hold_release_idle got=%b exp=1", i1.in_ready); end
        n_checks++; if (i1.out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release_ov got=%b exp=0", i1.out_valid); end
    endtask

    task automatic test_reset_mid_run();
        int n;
        bit seen;
        @(negedge clk);
        i1.a        = 8'h55;
        i1.b        = 8'h22;
        i1.sub_mode = 1'b0;
        i1.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i1.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (i1.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstrun_out_valid got=%b exp=0", i1.out_valid); end
        n_checks++; if (i1.res !== 8'h00)      begin n_fail++; $display("FAIL rstrun_res got=%h exp=00", i1.res); end
        n_checks++; if (i1.in_ready !== 1'b1)  begin n_fail++; $display("FAIL rstrun_in_ready got=%b exp=1", i1.in_ready); end
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (i1.out_valid) seen = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        n_checks++; if (seen !== 1'b0)         begin n_fail++; $display("FAIL rstrun_partial_presented got=%b exp=0", seen); end
        run_op1(8'h05, 8'h03, 1'b0, n);
        n_checks++; if (n !== 8)               begin n_fail++; $display("FAIL rstrun_next_latency got=%0d exp=8", n); end
        n_checks++; if (i1.res !== 8'h08)      begin n_fail++; $display("FAIL rstrun_next_res got=%h exp=08", i1.res); end
        release1();
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst          = 1'b1;
        i1.in_valid  = 1'b0;
        i1.a         = '0;
        i1.b         = '0;
        i1.sub_mode  = 1'b0;
        i1.out_ready = 1'b0;
        i4.in_valid  = 1'b0;
        i4.a         = '0;
        i4.b         = '0;
        i4.sub_mode  = 1'b0;
        i4.out_ready = 1'b0;

        test_reset();
        test_add();
        test_sub();
        test_overflow();
        test_digit4();
        test_hold();
        test_reset_mid_run();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
